// File: rtl/bitbakery_tx_scheduler.sv
// Frame sequencer for the status/map serial link: snapshots the game state once
// per frame and feeds it byte by byte to the UART TX core, then idles for a gap.
module bitbakery_tx_scheduler #(
    parameter int          MAP_BYTES  = 64,
    parameter int          GAP_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hFF
) (
    input  logic                   clock,
    input  logic                   reset_in,
    input  logic                   enable,
    input  logic [7:0]             D0,
    input  logic [7:0]             D1,
    input  logic [7:0]             D2,
    input  logic [8*MAP_BYTES-1:0] map_obstacles,
    input  logic [8*MAP_BYTES-1:0] map_objectives,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic [3:0]             db_estado
);

    localparam int         FRAME_LEN = 4 + 2 * MAP_BYTES;
    localparam logic [7:0] LAST_IDX  = 8'(FRAME_LEN - 1);
    localparam int         GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_HOLD = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5,
        S_GAP  = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             idx_q, idx_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [7:0]             d0_q, d1_q, d2_q;
    logic [8*MAP_BYTES-1:0] obs_q, obj_q;
    logic [7:0]             byte_sel;

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            obs_q   <= '0;
            obj_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            // The whole frame is taken from this one capture, so sources may change freely afterwards.
            if (state_q == S_LOAD) begin
                d0_q  <= D0;
                d1_q  <= D1;
                d2_q  <= D2;
                obs_q <= map_obstacles;
                obj_q <= map_objectives;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: if (enable) state_d = S_LOAD;
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: if (tx_ready) state_d = S_HOLD;
            // UART drops tx_ready one cycle late; skip that cycle so we never double-fire.
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_DONE: begin
                gap_d   = '0;
                state_d = enable ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_sel = '0;
        unique case (idx_q)
            8'd0:    byte_sel = SYNC_BYTE;
            8'd1:    byte_sel = d0_q;
            8'd2:    byte_sel = d1_q;
            8'd3:    byte_sel = d2_q;
            default: byte_sel = '0;
        endcase
        for (int k = 0; k < MAP_BYTES; k++) begin
            if (idx_q == 8'(4 + k))             byte_sel = obs_q[8*k +: 8];
            if (idx_q == 8'(4 + MAP_BYTES + k)) byte_sel = obj_q[8*k +: 8];
        end
    end

    always_comb begin
        tx_start   = (state_q == S_SEND) && tx_ready;
        tx_data    = (state_q == S_SEND || state_q == S_HOLD || state_q == S_WAIT) ? byte_sel : 8'h00;
        frame_busy = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_HOLD) ||
                     (state_q == S_WAIT) || (state_q == S_DONE);
        frame_done = (state_q == S_DONE);
        db_estado  = {1'b0, state_q};
    end

endmodule

// File: tb/tb_bitbakery_tx_scheduler.sv
// Randomized bench: a UART model plus a scoreboard that rebuilds each frame from the
// inputs present at frame load and checks every transmitted byte and the timing.
module tb_bitbakery_tx_scheduler;

    localparam int MB  = 64;
    localparam int GAP = 100;
    localparam int L   = 4 + 2 * MB;
    localparam int LIM = 20000;

    logic            clock, reset_in, enable, tx_ready;
    logic [7:0]      D0, D1, D2;
    logic [8*MB-1:0] map_obstacles, map_objectives;
    logic            tx_start, frame_busy, frame_done;
    logic [7:0]      tx_data;
    logic [3:0]      db_estado;

    bitbakery_tx_scheduler #(.MAP_BYTES(MB), .GAP_CYCLES(GAP), .SYNC_BYTE(8'hFF)) dut (
        .clock(clock), .reset_in(reset_in), .enable(enable),
        .D0(D0), .D1(D1), .D2(D2),
        .map_obstacles(map_obstacles), .map_objectives(map_objectives),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .frame_busy(frame_busy), .frame_done(frame_done), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_chk = 0, n_bad = 0;
    int         cyc = 0, nbytes = 0, n_start = 0, n_done = 0;
    int         done_cyc = 0, last_start = -100, cnt = 0, uart_lat = 10, bp_bad = 0;
    bit         pend = 0, gap_chk = 0, busy_prev = 0, force_low = 0, bp_arm = 0, bp_watch = 0;
    logic [7:0] bp_data = 8'h00;
    logic [7:0] exp_q [$];
    logic [7:0] cap [L];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame: sync, three status words, then each map LSB byte first.
    function automatic void push_frame();
        exp_q.push_back(8'hFF);
        exp_q.push_back(D0);
        exp_q.push_back(D1);
        exp_q.push_back(D2);
        for (int k = 0; k < MB; k++) exp_q.push_back(8'(map_obstacles >> (8 * k)));
        for (int k = 0; k < MB; k++) exp_q.push_back(8'(map_objectives >> (8 * k)));
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (reset_in) begin
            if (!enable) gap_chk = 0;
            if (frame_busy && !busy_prev) begin
                if (gap_chk) chk("gap_len", cyc - done_cyc, GAP + 1);
                chk("q_empty_at_load", exp_q.size(), 0);
                exp_q.delete();
                push_frame();
                nbytes = 0;
            end
            if (tx_start) begin
                chk("start_with_ready", tx_ready, 1);
                chk("start_in_send", db_estado, 2);
                chk("start_spacing", (cyc - last_start) >= 3, 1);
                last_start = cyc;
                n_start++;
                if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
                else chk("byte", tx_data, exp_q.pop_front());
                if (nbytes < L) cap[nbytes] = tx_data;
                nbytes++;
                pend = 1;
            end
            if (frame_done) begin
                chk("done_q_empty", exp_q.size(), 0);
                chk("done_nbytes", nbytes, L);
                n_done++;
                done_cyc = cyc;
                gap_chk  = enable;
            end
            if (bp_watch && tx_data !== bp_data) bp_bad++;
        end
        busy_prev = frame_busy;
    end

    // UART model: ready drops the cycle after tx_start is taken and returns uart_lat cycles later.
    always @(posedge clock) begin
        #1;
        if (!reset_in) begin
            cnt  = 0;
            pend = 0;
        end else begin
            if (pend) begin
                cnt  = uart_lat;
                pend = 0;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (bp_arm && db_estado == 4'd2 && !force_low) begin
                force_low = 1;
                bp_arm    = 0;
                bp_data   = tx_data;
                bp_watch  = 1;
            end
        end
        tx_ready = !force_low && (cnt == 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_bytes(input int n);
        int i = 0;
        while (!(frame_busy && nbytes == n) && i < LIM) begin
            tick(1);
            i++;
        end
        chk("wait_bytes_in_time", i < LIM, 1);
    endtask

    task automatic wait_done();
        int d = n_done;
        int i = 0;
        while (n_done == d && i < LIM) begin
            tick(1);
            i++;
        end
        chk("wait_done_in_time", n_done - d, 1);
    endtask

    task automatic randomize_inputs();
        D0 = 8'($urandom());
        D1 = 8'($urandom());
        D2 = 8'($urandom());
        for (int i = 0; i < MB / 4; i++) begin
            map_obstacles  = {map_obstacles[8*MB-33:0], 32'($urandom())};
            map_objectives = {map_objectives[8*MB-33:0], 32'($urandom())};
        end
    endtask

    initial begin
        int s;
        int i;
        reset_in = 1'b0;
        enable   = 1'b0;
        tx_ready = 1'b1;
        D0 = 8'h05; D1 = 8'h4A; D2 = 8'h83;
        map_obstacles  = '0;
        map_objectives = '0;
        map_obstacles[7:0]          = 8'hA5;
        map_objectives[8*MB-1 -: 8] = 8'h3C;
        #2;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_state", db_estado, 0);
        tick(3);
        reset_in = 1'b1;
        tick(5);
        chk("idle_without_enable", db_estado, 0);
        chk("idle_no_start", n_start, 0);

        // Basic frame, with the coherence change injected during byte 10.
        enable = 1'b1;
        wait_bytes(10);
        D0 = 8'h11;
        map_obstacles = '1;
        wait_done();
        chk("f1_count", nbytes, L);
        chk("f1_sync", cap[0], 8'hFF);
        chk("f1_d0", cap[1], 8'h05);
        chk("f1_obs0", cap[4], 8'hA5);
        chk("f1_obs1", cap[5], 8'h00);
        chk("f1_obj_last", cap[L-1], 8'h3C);
        chk("f1_one_done", n_done, 1);
        wait_done();
        chk("f2_d0", cap[1], 8'h11);
        chk("f2_d1", cap[2], 8'h4A);
        chk("f2_obs0", cap[4], 8'hFF);
        chk("f2_obs_last", cap[4+MB-1], 8'hFF);
        chk("f2_obj_last", cap[L-1], 8'h3C);

        // Random frames; one with a UART that never drops ready.
        for (int r = 0; r < 3; r++) begin
            uart_lat = (r == 1) ? 0 : int'($urandom_range(1, 12));
            wait_bytes(int'($urandom_range(2, 120)));
            randomize_inputs();
            wait_done();
        end
        uart_lat = 10;

        // Enable dropped during the gap returns straight to idle.
        tick(20);
        chk("in_gap", db_estado, 6);
        enable = 1'b0;
        tick(1);
        chk("gap_abort_idle", db_estado, 0);
        s = n_start;
        tick(10);
        chk("gap_abort_quiet", n_start - s, 0);

        // Enable dropped mid-frame: frame finishes, then idle.
        enable = 1'b1;
        wait_bytes(50);
        enable = 1'b0;
        wait_done();
        tick(2);
        chk("drop_idle", db_estado, 0);
        chk("drop_busy", frame_busy, 0);
        s = n_start;
        tick(300);
        chk("drop_quiet", n_start - s, 0);

        // Back-pressure while a byte is pending in SEND.
        enable   = 1'b1;
        uart_lat = 6;
        wait_bytes(30);
        bp_arm = 1;
        i = 0;
        while (!force_low && i < LIM) begin
            tick(1);
            i++;
        end
        chk("bp_armed", force_low, 1);
        s = n_start;
        tick(1000);
        chk("bp_no_start", n_start - s, 0);
        chk("bp_data_stable", bp_bad, 0);
        chk("bp_in_send", db_estado, 2);
        force_low = 0;
        bp_watch  = 0;
        tick(4);
        chk("bp_one_start", n_start - s, 1);
        chk("bp_byte", cap[nbytes-1], bp_data);
        wait_done();

        // Asynchronous reset mid-frame.
        randomize_inputs();
        wait_bytes(20);
        @(negedge clock);
        #3;
        reset_in = 1'b0;
        exp_q.delete();
        nbytes  = 0;
        gap_chk = 0;
        last_start = -100;
        #1;
        chk("arst_tx_start", tx_start, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_busy", frame_busy, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_state", db_estado, 0);
        s = n_start;
        tick(4);
        chk("arst_quiet", n_start - s, 0);
        reset_in = 1'b1;
        wait_bytes(1);
        chk("arst_restart_sync", cap[0], 8'hFF);
        wait_done();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
